gb_timer_v2: RTL and testbench
==============================

Name: gb_timer_v2

Overview:
- Parametrised successor to the DMG timer/divider peripheral. It sits on the peripheral bus at BASE_ADDR..BASE_ADDR+3, mapping DIV, TIMA, TMA and TAC.
- TIMA is clocked from the falling edge of a selected DIV bit ANDed with the TAC enable, so DIV writes and TAC writes can cause increments.
- TIMA overflow is handled by a delayed-reload state machine: zero-window, then reload-window, then a timer interrupt request.

Parameters:
- DIV_WIDTH, 16, internal divider width (>=10); CPU sees the upper 8 bits.
- RELOAD_DELAY, 4, clk cycles spent in each of the OVF and RELOAD windows (>=1).
- BASE_ADDR, 16'hFF04, address of DIV; TIMA/TMA/TAC follow at +1/+2/+3.

Ports:
- clk  input  1  t-cycle clock
- reset  input  1  reset, asynchronous, active-high
- addr  input  16  bus address
- wdata  input  8  bus write data
- write_en  input  1  write strobe, sampled at posedge clk
- read_en  input  1  read strobe
- rdata  output  8  combinational read data
- timer_req  output  1  one-clk interrupt request pulse

Behaviour:
- Reset: DIV=0, TIMA=0, TMA=0, TAC=0, tick_prev=0, state=IDLE, delay counter=0, timer_req=0.
- DIV: increments by 1 every clk and wraps at 2^DIV_WIDTH. A write to DIV (any data) sets it to 0 on that edge; the write takes precedence over the increment. The read returns DIV[DIV_WIDTH-1:DIV_WIDTH-8].
- Tap select by TAC[1:0]: 00 selects DIV bit 9, 01 bit 3, 10 bit 5, 11 bit 7.
- tick_in = TAC[2] & DIV[tap], computed from the registered DIV/TAC. tick_prev <= tick_in every clk.
- Increment event: tick_prev=1 and tick_in=0. Consequences:
  - A DIV reset while the tapped bit is 1 yields one increment one clk later.
  - Clearing TAC[2], or switching the tap, while tick_in=1 yields one increment.
- States:
  - IDLE: on an increment event, if TIMA!=FF then TIMA<=TIMA+1. If TIMA==FF then TIMA<=00 and go to OVF with counter=0.
  - OVF: TIMA holds 00 and increment events are ignored. The counter counts 0..RELOAD_DELAY-1. On the last count: TIMA<=TMA, timer_req<=1 (one clk), go to RELOAD.
  - RELOAD: lasts RELOAD_DELAY clks, then returns to IDLE. Increment events are ignored.
- Writes during the overflow sequence:
  - TIMA write in OVF: TIMA<=wdata, return to IDLE, reload and IRQ cancelled.
  - TIMA write in RELOAD: ignored.
  - TMA write in RELOAD: TMA<=wdata and TIMA<=wdata on the same edge.
- TIMA write in IDLE in the same cycle as an increment event: the write wins and no increment is applied.
- TMA/TAC writes in IDLE take effect on the next edge. TAC stores wdata[2:0].
- Reads: rdata=FF unless read_en is high and the address matches a register. TAC reads as {5'b11111, TAC[2:0]}. rdata reflects current register contents with no wait states.
- Reset asserted mid-sequence (OVF/RELOAD) returns to IDLE immediately with no IRQ.
- Writes to unmapped addresses have no effect.

Optional Feature:
- Macro: TIMER_DEBUG_PORTS_EN.
- With the macro defined, two extra outputs are added:
  - div_full [DIV_WIDTH-1:0]: the raw counter.
  - tima_tick [1]: high for one clk on every accepted TIMA increment, including FF->00.
- Without the macro, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- TAC=05 (bit 3), TIMA=00, DIV reset: after 16 clks TIMA=01 and after 160 clks TIMA=0A; DIV readback = upper 8 bits of the cycle count.
- TIMA=FE, TMA=AB, TAC=05: the second increment gives TIMA=00 for 4 clks, then TIMA=AB with timer_req high for exactly 1 clk; timer_req stays low at every other clk.
- Overflow then TIMA write of 0x33 during OVF: TIMA=33, no timer_req, no reload. Write of 0x33 during RELOAD instead: ignored, TIMA=TMA. TMA write of 0x77 during RELOAD: TIMA=77.
- TAC=05, DIV advanced to 8 (bit 3 set), then DIV write: TIMA increments by exactly 1 one clk later. Same precondition with TAC written to 01: one increment.
- Reads: TAC written with FF reads back FF, TAC written with 00 reads F8. Unmapped address 0xFF08 reads FF. read_en=0 reads FF.
- Reset asserted in OVF: all registers 0, timer_req 0, and normal counting resumes after release.

Source files
------------

// File: rtl/gb_timer_v2.sv
// gb_timer_v2 -- DMG-style timer/divider peripheral with delayed TIMA reload.
//
// Register map (BASE_ADDR = DIV):
//   +0 DIV  : upper 8 bits of the free-running divider; any write clears it
//   +1 TIMA : timer counter, clocked by falling edges of the selected DIV tap
//   +2 TMA  : reload value applied after a TIMA overflow
//   +3 TAC  : [2] enable, [1:0] tap select (00:bit9 01:bit3 10:bit5 11:bit7)
//
// Overflow handling: IDLE -> OVF (TIMA reads 00 for RELOAD_DELAY clks)
// -> RELOAD (TIMA = TMA, timer_req pulses once, lasts RELOAD_DELAY clks)
// -> IDLE.
//
// Ports:
//   clk        t-cycle clock
//   reset      asynchronous, active-high reset
//   addr       bus address
//   wdata      bus write data
//   write_en   write strobe, sampled at posedge clk
//   read_en    read strobe
//   rdata      combinational read data (FF when nothing is selected)
//   timer_req  one-clk interrupt request pulse
//
// Optional build macro TIMER_DEBUG_PORTS_EN adds:
//   div_full   raw divider counter
//   tima_tick  one-clk pulse on every accepted TIMA increment (incl. FF->00)

module gb_timer_v2 #(
  parameter int unsigned DIV_WIDTH    = 16,
  parameter int unsigned RELOAD_DELAY = 4,
  parameter logic [15:0] BASE_ADDR    = 16'hFF04
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          addr,
  input  logic [7:0]           wdata,
  input  logic                 write_en,
  input  logic                 read_en,
  output logic [7:0]           rdata,
`ifdef TIMER_DEBUG_PORTS_EN
  output logic [DIV_WIDTH-1:0] div_full,
  output logic                 tima_tick,
`endif
  output logic                 timer_req
);

  localparam int unsigned CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_DELAY - 1);

  localparam logic [15:0] ADDR_DIV  = BASE_ADDR;
  localparam logic [15:0] ADDR_TIMA = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_TMA  = BASE_ADDR + 16'd2;
  localparam logic [15:0] ADDR_TAC  = BASE_ADDR + 16'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } state_e;

  // Architectural state
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           tima_q;
  logic [7:0]           tma_q;
  logic [2:0]           tac_q;
  logic                 tick_prev_q;
  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 timer_req_q;

  // Address decode
  logic wr_div, wr_tima, wr_tma, wr_tac;
  assign wr_div  = write_en && (addr == ADDR_DIV);
  assign wr_tima = write_en && (addr == ADDR_TIMA);
  assign wr_tma  = write_en && (addr == ADDR_TMA);
  assign wr_tac  = write_en && (addr == ADDR_TAC);

  // Divider: a write clears it and takes precedence over the increment.
  assign div_d = wr_div ? '0 : div_q + DIV_WIDTH'(1);

  // Tap multiplexer and falling-edge detector. Because tick_in is built from
  // registered DIV/TAC, clearing DIV, clearing the enable or moving the tap
  // while the tapped bit is high all look like a falling edge.
  logic tap_bit;
  logic tick_in;
  logic inc_evt;

  // NOTE: every combinational block assigns a default first so that no path
  // leaves an output unassigned, which would otherwise infer a latch.
  always_comb begin
    tap_bit = 1'b0;
    unique case (tac_q[1:0])
      2'b00: tap_bit = div_q[9];
      2'b01: tap_bit = div_q[3];
      2'b10: tap_bit = div_q[5];
      2'b11: tap_bit = div_q[7];
    endcase
  end

  assign tick_in = tac_q[2] & tap_bit;
  assign inc_evt = tick_prev_q & ~tick_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      tac_q       <= 3'b000;
      tick_prev_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      tick_prev_q <= tick_in;
      if (wr_tac) tac_q <= wdata[2:0];
    end
  end

`ifdef TIMER_DEBUG_PORTS_EN
  logic tima_tick_q;
`endif

  // TIMA / TMA / overflow-reload state machine
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tima_q      <= 8'h00;
      tma_q       <= 8'h00;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timer_req_q <= 1'b0;
`ifdef TIMER_DEBUG_PORTS_EN
      tima_tick_q <= 1'b0;
`endif
    end else begin
      timer_req_q <= 1'b0;
`ifdef TIMER_DEBUG_PORTS_EN
      tima_tick_q <= 1'b0;
`endif
      if (wr_tma) tma_q <= wdata;

      unique case (state_q)
        ST_IDLE: begin
          // A CPU write to TIMA wins over a coincident increment.
          if (wr_tima) begin
            tima_q <= wdata;
          end else if (inc_evt) begin
`ifdef TIMER_DEBUG_PORTS_EN
            tima_tick_q <= 1'b1;
`endif
            if (tima_q == 8'hFF) begin
              tima_q  <= 8'h00;
              state_q <= ST_OVF;
              cnt_q   <= '0;
            end else begin
              tima_q <= tima_q + 8'd1;
            end
          end
        end

        ST_OVF: begin
          if (wr_tima) begin
            // Writing TIMA inside the zero window cancels reload and IRQ.
            tima_q  <= wdata;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            tima_q      <= wr_tma ? wdata : tma_q;
            timer_req_q <= 1'b1;
            state_q     <= ST_RELOAD;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RELOAD: begin
          // TIMA writes are dropped here; a TMA write lands in TIMA as well.
          if (wr_tma) tima_q <= wdata;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign timer_req = timer_req_q;

`ifdef TIMER_DEBUG_PORTS_EN
  assign div_full  = div_q;
  assign tima_tick = tima_tick_q;
`endif

  // Read mux: unselected or unmapped reads float high as FF.
  always_comb begin
    rdata = 8'hFF;
    if (read_en) begin
      unique case (addr)
        ADDR_DIV:  rdata = div_q[DIV_WIDTH-1 -: 8];
        ADDR_TIMA: rdata = tima_q;
        ADDR_TMA:  rdata = tma_q;
        ADDR_TAC:  rdata = {5'b11111, tac_q};
        default:   rdata = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_timer_v2.sv
// Self-checking bench for gb_timer_v2 (default parameters, debug ports off).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the falling edge, half a period away from the active rising edge.

module tb_gb_timer_v2;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        write_en;
  logic        read_en;
  logic [7:0]  rdata;
  logic        timer_req;

  int n_cmp  = 0;
  int n_fail = 0;

  gb_timer_v2 dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .write_en  (write_en),
    .read_en   (read_en),
    .rdata     (rdata),
    .timer_req (timer_req)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h", name, act, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the next rising edge and the
  // task returns on the falling edge after it.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr     = a;
    wdata    = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    addr     = 16'h0000;
    wdata    = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    addr    = a;
    read_en = 1'b1;
    #1 d    = rdata;
    read_en = 1'b0;
    addr    = 16'h0000;
  endtask

  task automatic check_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench on the falling edge after the TIMA write, one rising
  // edge after the DIV clear (k = 1 counted from the DIV clear edge).
  task automatic setup_seq(input logic [7:0] tma, input logic [7:0] tima);
    bus_write(A_TMA, tma);
    bus_write(A_TAC, 8'h05);
    bus_write(A_DIV, 8'h00);
    bus_write(A_TIMA, tima);
  endtask

  // Expected TIMA for TIMA=FE, TMA=AB, tap bit 3, k edges after the DIV
  // clear: bit 3 falls when DIV reaches 16*n, the increment lands one edge
  // later (k = 17, 33), TIMA sits at 00 for four edges, reload at k = 37.
  function automatic logic [7:0] exp_ovf_tima(input int k);
    if (k < 17)      return 8'hFE;
    else if (k < 33) return 8'hFF;
    else if (k < 37) return 8'h00;
    else             return 8'hAB;
  endfunction

  initial begin
    logic [7:0] d;

    reset    = 1'b1;
    addr     = 16'h0000;
    wdata    = 8'h00;
    write_en = 1'b0;
    read_en  = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_req",  {7'b0, timer_req}, 8'h00);
    check_reg("rst_div",  A_DIV,  8'h00);
    check_reg("rst_tima", A_TIMA, 8'h00);
    check_reg("rst_tma",  A_TMA,  8'h00);
    check_reg("rst_tac",  A_TAC,  8'hF8);
    cycles(3);
    reset = 1'b0;
    cycles(1);

    // ---------------- register access table ----------------
    vecs[0]  = '{"wr_tac_ff",    A_TAC,    8'hFF, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{"rd_tac_ff",    A_TAC,    8'h00, 1'b0, 1'b1, 1'b1, 8'hFF};
    vecs[2]  = '{"wr_tac_00",    A_TAC,    8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{"rd_tac_00",    A_TAC,    8'h00, 1'b0, 1'b1, 1'b1, 8'hF8};
    vecs[4]  = '{"wr_tma_5a",    A_TMA,    8'h5A, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{"rd_tma_5a",    A_TMA,    8'h00, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[6]  = '{"rd_unmapped",  16'hFF08, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF};
    vecs[7]  = '{"rd_no_en",     A_TMA,    8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[8]  = '{"wr_unmapped",  16'hFF08, 8'h07, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{"rd_tac_after", A_TAC,    8'h00, 1'b0, 1'b1, 1'b1, 8'hF8};
    vecs[10] = '{"rd_tma_after", A_TMA,    8'h00, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[11] = '{"wr_tima_42",   A_TIMA,   8'h42, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{"rd_tima_42",   A_TIMA,   8'h00, 1'b0, 1'b1, 1'b1, 8'h42};
    vecs[13] = '{"rd_below",     16'hFF03, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF};

    for (int i = 0; i < 14; i++) begin
      addr     = vecs[i].addr;
      wdata    = vecs[i].wdata;
      write_en = vecs[i].we;
      read_en  = vecs[i].re;
      #1;
      if (vecs[i].chk) check(vecs[i].name, rdata, vecs[i].exp);
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b0;
    end

    // ---------------- basic counting on bit 3 ----------------
    bus_write(A_TAC, 8'h05);
    bus_write(A_DIV, 8'h00);       // DIV cleared at edge k = 0
    bus_write(A_TIMA, 8'h00);      // k = 1
    cycles(15);                    // k = 16
    check_reg("cnt_k16",  A_TIMA, 8'h00);
    cycles(1);                     // k = 17
    check_reg("cnt_k17",  A_TIMA, 8'h01);
    cycles(143);                   // k = 160
    check_reg("cnt_k160", A_TIMA, 8'h09);
    cycles(1);                     // k = 161
    check_reg("cnt_k161", A_TIMA, 8'h0A);
    check_reg("div_k161", A_DIV,  8'h00);
    cycles(94);                    // k = 255
    check_reg("div_k255", A_DIV,  8'h00);
    cycles(1);                     // k = 256
    check_reg("div_k256", A_DIV,  8'h01);

    // ---------------- overflow and delayed reload ----------------
    setup_seq(8'hAB, 8'hFE);
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) cycles(1);
      check_reg($sformatf("ovf_tima_k%0d", k), A_TIMA, exp_ovf_tima(k));
      check($sformatf("ovf_req_k%0d", k), {7'b0, timer_req}, (k == 37) ? 8'h01 : 8'h00);
    end

    // ---------------- TIMA write in the zero window ----------------
    setup_seq(8'hAB, 8'hFE);
    cycles(32);                    // k = 33, first OVF clk
    check_reg("ovfw_zero", A_TIMA, 8'h00);
    bus_write(A_TIMA, 8'h33);      // k = 34
    for (int k = 34; k <= 45; k++) begin
      if (k > 34) cycles(1);
      check_reg($sformatf("ovfw_tima_k%0d", k), A_TIMA, 8'h33);
      check($sformatf("ovfw_req_k%0d", k), {7'b0, timer_req}, 8'h00);
    end

    // ---------------- TIMA write in the reload window ----------------
    setup_seq(8'hAB, 8'hFE);
    cycles(36);                    // k = 37
    check("rldw_req", {7'b0, timer_req}, 8'h01);
    bus_write(A_TIMA, 8'h33);      // k = 38, dropped
    check_reg("rldw_tima_k38", A_TIMA, 8'hAB);
    check("rldw_req_k38", {7'b0, timer_req}, 8'h00);
    cycles(7);                     // k = 45
    check_reg("rldw_tima_k45", A_TIMA, 8'hAB);

    // ---------------- TMA write in the reload window ----------------
    setup_seq(8'hAB, 8'hFE);
    cycles(36);                    // k = 37
    check_reg("rldm_tima_k37", A_TIMA, 8'hAB);
    bus_write(A_TMA, 8'h77);       // k = 38
    check_reg("rldm_tima_k38", A_TIMA, 8'h77);
    check_reg("rldm_tma_k38",  A_TMA,  8'h77);
    cycles(7);                     // k = 45

    // ---------------- DIV clear while tapped bit is high ----------------
    setup_seq(8'h00, 8'h10);
    cycles(7);                     // k = 8, DIV = 8, bit 3 high
    bus_write(A_DIV, 8'h00);       // clear at k = 9
    check_reg("divg_same",  A_TIMA, 8'h10);
    cycles(1);
    check_reg("divg_next",  A_TIMA, 8'h11);
    cycles(10);
    check_reg("divg_later", A_TIMA, 8'h11);

    // ---------------- TAC enable cleared while tick_in is high -------------
    setup_seq(8'h00, 8'h10);
    cycles(7);                     // k = 8
    bus_write(A_TAC, 8'h01);       // enable dropped at k = 9
    check_reg("tacg_same",  A_TIMA, 8'h10);
    cycles(1);
    check_reg("tacg_next",  A_TIMA, 8'h11);
    cycles(40);
    check_reg("tacg_later", A_TIMA, 8'h11);

    // ---------------- reset during OVF ----------------
    setup_seq(8'hAB, 8'hFE);
    cycles(33);                    // k = 34, inside OVF
    check_reg("mrst_pre", A_TIMA, 8'h00);
    reset = 1'b1;
    #1;
    check("mrst_req", {7'b0, timer_req}, 8'h00);
    check_reg("mrst_div",  A_DIV,  8'h00);
    check_reg("mrst_tima", A_TIMA, 8'h00);
    check_reg("mrst_tma",  A_TMA,  8'h00);
    check_reg("mrst_tac",  A_TAC,  8'hF8);
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check($sformatf("mrst_req_hold%0d", i), {7'b0, timer_req}, 8'h00);
    end
    reset = 1'b0;
    bus_write(A_TAC, 8'h05);       // first edge after release, j = 1
    for (int j = 1; j <= 20; j++) begin
      if (j > 1) cycles(1);
      check($sformatf("mrst_req_j%0d", j), {7'b0, timer_req}, 8'h00);
    end                            // j = 20 here
    check_reg("mrst_tima_j20", A_TIMA, 8'h01);
    cycles(236);                   // j = 256
    check_reg("mrst_div_j256", A_DIV, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
